// File: rtl/vme_cmd_master.sv
// rtl/vme_cmd_master.sv - single-command A24/D16 VME bus master fed by a command request/capture handshake
module vme_cmd_master #(
    parameter int unsigned GAP_CYC     = 4,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned TIMEOUT_CYC = 1023,
    parameter logic [5:0]  AM_CODE     = 6'h39
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] vme_cmd_reg,
    input  logic [31:0] vme_dat_reg_in,
    output logic        vme_cmd_rd,
    output logic        vme_dat_wr,
    output logic [31:0] vme_dat_reg_out,
    output logic [22:0] vme_addr,
    output logic [5:0]  vme_am,
    output logic        vme_write_b,
    output logic        vme_as_b,
    output logic [1:0]  vme_ds_b,
    output logic [15:0] vme_data_out,
    output logic        vme_data_oe,
    input  logic [15:0] vme_data_in,
    input  logic        vme_dtack_b,
    input  logic        vme_berr_b,
    output logic [7:0]  err_cnt
);
    localparam int GW = $clog2(GAP_CYC + 1);
    localparam int SW = $clog2(SETUP_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [31:0] RES_BERR    = 32'h4000_FFFF;
    localparam logic [31:0] RES_TIMEOUT = 32'h8000_FFFF;

    typedef enum logic [2:0] {IDLE, REQ, CAPTURE, SETUP, STROBE, RELEASE, DONE} state_t;

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic [SW-1:0] set_cnt;
    logic [TW-1:0] to_cnt;
    logic          rd_lat;
    logic          timed_out;
    logic [31:0]   result;
    logic          dtack_m, dtack_s, berr_m, berr_s;
    logic          to_done;

    logic unused_bits;
    assign unused_bits = ^{vme_cmd_reg[31:26], vme_cmd_reg[24], vme_cmd_reg[0], vme_dat_reg_in[31:16]};

    assign to_done = (to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            gap_cnt         <= GW'(GAP_CYC);
            set_cnt         <= '0;
            to_cnt          <= '0;
            rd_lat          <= 1'b0;
            timed_out       <= 1'b0;
            result          <= '0;
            dtack_m         <= 1'b1;
            dtack_s         <= 1'b1;
            berr_m          <= 1'b1;
            berr_s          <= 1'b1;
            vme_cmd_rd      <= 1'b0;
            vme_dat_wr      <= 1'b0;
            vme_dat_reg_out <= '0;
            vme_addr        <= '0;
            vme_am          <= '0;
            vme_write_b     <= 1'b1;
            vme_as_b        <= 1'b1;
            vme_ds_b        <= 2'b11;
            vme_data_out    <= '0;
            vme_data_oe     <= 1'b0;
            err_cnt         <= '0;
        end else begin
            dtack_m    <= vme_dtack_b;
            dtack_s    <= dtack_m;
            berr_m     <= vme_berr_b;
            berr_s     <= berr_m;
            vme_cmd_rd <= 1'b0;
            vme_dat_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (gap_cnt <= GW'(1)) begin
                        vme_cmd_rd <= 1'b1;
                        state      <= REQ;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                REQ: state <= CAPTURE;
                CAPTURE: begin
                    if (start) begin
                        rd_lat       <= vme_cmd_reg[25];
                        vme_addr     <= vme_cmd_reg[23:1];
                        vme_am       <= AM_CODE;
                        vme_write_b  <= vme_cmd_reg[25];
                        vme_data_out <= vme_dat_reg_in[15:0];
                        vme_data_oe  <= ~vme_cmd_reg[25];
                        set_cnt      <= SW'(SETUP_CYC);
                        state        <= SETUP;
                    end else begin
                        gap_cnt <= GW'(GAP_CYC);
                        state   <= IDLE;
                    end
                end
                SETUP: begin
                    if (set_cnt <= SW'(1)) begin
                        vme_as_b <= 1'b0;
                        vme_ds_b <= 2'b00;
                        to_cnt   <= '0;
                        state    <= STROBE;
                    end else begin
                        set_cnt <= set_cnt - SW'(1);
                    end
                end
                STROBE: begin
                    // BERR takes priority over a simultaneous DTACK
                    if (!berr_s || !dtack_s || to_done) begin
                        vme_as_b    <= 1'b1;
                        vme_ds_b    <= 2'b11;
                        vme_data_oe <= 1'b0;
                        state       <= RELEASE;
                        if (!berr_s || dtack_s) begin
                            err_cnt <= (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
                        end
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
                    if (!berr_s) begin
                        result    <= RES_BERR;
                        timed_out <= 1'b0;
                    end else if (!dtack_s) begin
                        result    <= rd_lat ? {16'h0000, vme_data_in} : 32'h0;
                        timed_out <= 1'b0;
                    end else if (to_done) begin
                        result    <= RES_TIMEOUT;
                        timed_out <= 1'b1;
                    end
                end
                RELEASE: begin
                    // a timed-out slave may never release, so do not wait on it
                    if (timed_out || (dtack_s && berr_s)) begin
                        vme_dat_wr      <= 1'b1;
                        vme_write_b     <= 1'b1;
                        vme_dat_reg_out <= result;
                        state           <= DONE;
                    end
                end
                DONE: begin
                    gap_cnt <= GW'(GAP_CYC);
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vme_cmd_master.sv
// tb/tb_vme_cmd_master.sv - table-driven scoreboard bench for vme_cmd_master with a behavioural VME slave
module tb_vme_cmd_master;
    localparam int GAP   = 4;
    localparam int SETUP = 2;
    localparam int TO    = 15;

    localparam int M_DTACK = 0;
    localparam int M_BERR  = 1;
    localparam int M_NONE  = 2;

    logic        clk, rst, start;
    logic [31:0] cmd, dat;
    logic        vme_cmd_rd, vme_dat_wr;
    logic [31:0] vme_dat_reg_out;
    logic [22:0] vme_addr;
    logic [5:0]  vme_am;
    logic        vme_write_b, vme_as_b;
    logic [1:0]  vme_ds_b;
    logic [15:0] vme_data_out;
    logic        vme_data_oe;
    logic [15:0] vme_data_in;
    logic        vme_dtack_b, vme_berr_b;
    logic [7:0]  err_cnt;

    vme_cmd_master #(.GAP_CYC(GAP), .SETUP_CYC(SETUP), .TIMEOUT_CYC(TO), .AM_CODE(6'h39)) dut (
        .clk(clk), .rst(rst), .start(start),
        .vme_cmd_reg(cmd), .vme_dat_reg_in(dat),
        .vme_cmd_rd(vme_cmd_rd), .vme_dat_wr(vme_dat_wr), .vme_dat_reg_out(vme_dat_reg_out),
        .vme_addr(vme_addr), .vme_am(vme_am), .vme_write_b(vme_write_b),
        .vme_as_b(vme_as_b), .vme_ds_b(vme_ds_b),
        .vme_data_out(vme_data_out), .vme_data_oe(vme_data_oe), .vme_data_in(vme_data_in),
        .vme_dtack_b(vme_dtack_b), .vme_berr_b(vme_berr_b), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] cmd;
        logic [31:0] dat;
        logic        start;
        int          mode;
        int          delay;
        logic [15:0] rdata;
        logic [31:0] out;
    } vec_t;

    typedef struct {
        logic [31:0] out;
        logic [7:0]  err;
        logic [22:0] addr;
        int          mode;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          err_model = 0;

    int          s_mode = M_NONE, s_delay = 0, s_cnt = 0, berr_hold = 0, berr_hi = 0;
    logic [15:0] s_rdata = 16'h0;
    logic [22:0] cur_addr = '0;
    logic        cur_rd = 1'b0;
    logic [15:0] cur_wdata = '0;

    int cyc = 0, last_done = 0, last_rd = 0, as_low = 0;
    bit have_done = 0, have_rd = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_cmd_rd", vme_cmd_rd, 0);
        chk("rst_dat_wr", vme_dat_wr, 0);
        chk("rst_dat_reg_out", vme_dat_reg_out, 0);
        chk("rst_addr", vme_addr, 0);
        chk("rst_am", vme_am, 0);
        chk("rst_write_b", vme_write_b, 1);
        chk("rst_as_b", vme_as_b, 1);
        chk("rst_ds_b", vme_ds_b, 2'b11);
        chk("rst_data_out", vme_data_out, 0);
        chk("rst_data_oe", vme_data_oe, 0);
        chk("rst_err_cnt", err_cnt, 0);
    endtask

    // monitor, scoreboard pop and behavioural slave share one process so their ordering is fixed
    always @(negedge clk) begin
        if (rst) begin
            have_done = 0; have_rd = 0; as_low = 0;
            s_cnt = 0; berr_hold = 0;
            vme_dtack_b = 1'b1; vme_berr_b = 1'b1; vme_data_in = 16'hDEAD;
        end else begin
            cyc++;
            berr_hi = vme_berr_b ? berr_hi + 1 : 0;
            if (vme_cmd_rd) begin
                if (have_done) chk("gap_after_done", cyc - last_done, GAP + 1);
                else if (have_rd) chk("gap_after_skip", cyc - last_rd, GAP + 2);
                have_done = 0; have_rd = 1; last_rd = cyc; as_low = 0;
            end
            if (!vme_as_b) begin
                as_low++;
                chk("strobe_addr", vme_addr, cur_addr);
                chk("strobe_am", vme_am, 6'h39);
                chk("strobe_write_b", vme_write_b, cur_rd);
                chk("strobe_ds_b", vme_ds_b, 2'b00);
                chk("strobe_oe", vme_data_oe, !cur_rd);
                if (!cur_rd) chk("strobe_data_out", vme_data_out, cur_wdata);
            end
            if (vme_dat_wr) begin
                if (sb.size() == 0) begin
                    chk("unexpected_dat_wr", vme_dat_wr, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("dat_reg_out", vme_dat_reg_out, e.out);
                    chk("err_cnt", err_cnt, e.err);
                    chk("done_write_b", vme_write_b, 1);
                    chk("done_as_ds", {vme_as_b, vme_ds_b}, 3'b111);
                    chk("done_oe", vme_data_oe, 0);
                    chk("done_addr_hold", vme_addr, e.addr);
                    if (e.mode == M_NONE) chk("timeout_strobe_len", as_low, TO);
                    if (e.mode == M_BERR) chk("berr_release_wait", berr_hi >= 3, 1);
                end
                have_done = 1; last_done = cyc;
            end
            if (vme_ds_b == 2'b00) begin
                if (s_cnt >= s_delay && s_mode != M_NONE) begin
                    vme_dtack_b = 1'b0;
                    vme_data_in = s_rdata;
                    if (s_mode == M_BERR) vme_berr_b = 1'b0;
                end
                s_cnt++;
            end else begin
                s_cnt = 0;
                vme_dtack_b = 1'b1;
                vme_data_in = 16'hDEAD;
                if (!vme_berr_b) begin
                    if (berr_hold >= 2) vme_berr_b = 1'b1;
                    else berr_hold++;
                end else begin
                    berr_hold = 0;
                end
            end
        end
    end

    task automatic wait_cmd_rd();
        int n = 0;
        while (!vme_cmd_rd && n < 200) begin @(negedge clk); n++; end
        chk("cmd_rd_seen", vme_cmd_rd, 1);
    endtask

    task automatic run(input vec_t v);
        int n;
        bit bad;
        exp_t e;
        wait_cmd_rd();
        cmd = v.cmd; dat = v.dat; start = v.start;
        s_mode = v.mode; s_delay = v.delay; s_rdata = v.rdata;
        if (v.start) begin
            cur_addr = v.cmd[23:1]; cur_rd = v.cmd[25]; cur_wdata = v.dat[15:0];
            if (v.mode != M_DTACK && err_model < 255) err_model++;
            e.out = v.out; e.err = 8'(err_model); e.addr = v.cmd[23:1]; e.mode = v.mode;
            sb.push_back(e);
        end
        @(negedge clk);
        chk("cmd_rd_one_cycle", vme_cmd_rd, 0);
        @(negedge clk);
        start = 1'b0;
        if (v.start) begin
            n = 0;
            while (sb.size() != 0 && n < 400) begin @(negedge clk); n++; end
            chk("completion_seen", sb.size(), 0);
        end else begin
            bad = 0; n = 0;
            while (!vme_cmd_rd && n < 50) begin
                if (!vme_as_b || vme_dat_wr) bad = 1;
                @(negedge clk); n++;
            end
            chk("skip_no_bus", bad, 0);
        end
    endtask

    vec_t vecs[8];
    vec_t v_rd;

    initial begin
        rst = 1'b1; start = 1'b0; cmd = '0; dat = '0;
        vme_dtack_b = 1'b1; vme_berr_b = 1'b1; vme_data_in = 16'hDEAD;
        vecs[0] = '{32'h00F8_3000, 32'h0000_1234, 1'b1, M_DTACK, 3, 16'h0000, 32'h0000_0000};
        vecs[1] = '{32'h02F8_4100, 32'h0000_0000, 1'b1, M_DTACK, 3, 16'hBEEF, 32'h0000_BEEF};
        vecs[2] = '{32'h0200_0010, 32'h0000_0000, 1'b1, M_NONE,  0, 16'h0000, 32'h8000_FFFF};
        vecs[3] = '{32'h0000_0200, 32'h0000_5555, 1'b1, M_BERR,  2, 16'h0000, 32'h4000_FFFF};
        vecs[4] = '{32'h0000_0400, 32'h0000_0000, 1'b0, M_NONE,  0, 16'h0000, 32'h0000_0000};
        vecs[5] = '{32'hFD00_0002, 32'hFFFF_A5A5, 1'b1, M_DTACK, 1, 16'h0000, 32'h0000_0000};
        vecs[6] = '{32'h02FF_FFFE, 32'h0000_0000, 1'b1, M_DTACK, 0, 16'hFFFF, 32'h0000_FFFF};
        vecs[7] = '{32'h0200_0002, 32'h0000_0000, 1'b1, M_DTACK, 5, 16'h0001, 32'h0000_0001};
        v_rd    = '{32'h0212_3456, 32'h0000_0000, 1'b1, M_DTACK, 2, 16'hC0DE, 32'h0000_C0DE};

        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run(vecs[i]);

        // reset in the middle of a strobe: lines must release before the next edge
        wait_cmd_rd();
        cmd = 32'h0200_0100; dat = '0; start = 1'b1;
        s_mode = M_NONE; s_delay = 0;
        cur_addr = 23'h000080; cur_rd = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        begin
            int n = 0;
            while (vme_as_b && n < 50) begin @(negedge clk); n++; end
        end
        chk("as_low_before_rst", vme_as_b, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_as_b", vme_as_b, 1);
        chk("async_rst_ds_b", vme_ds_b, 2'b11);
        chk("async_rst_oe", vme_data_oe, 0);
        check_reset_vals();
        sb.delete();
        err_model = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run(v_rd);

        // drive err_cnt past its saturation point
        for (int i = 0; i < 257; i++) begin
            vec_t vb;
            vb = '{32'h0000_0000 | (i << 1), 32'h0000_0000, 1'b1, M_BERR, 0, 16'h0000, 32'h4000_FFFF};
            run(vb);
        end
        chk("err_cnt_saturated", err_cnt, 8'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
